// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings: MEM-stage PC source select and the hazard-control FSM state.
// The branch-resolution helper lives here so every stage decodes PCSrc the same way.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PC4 = 3'd0,
    BEQ = 3'd1,
    BNE = 3'd2,
    J   = 3'd3,
    JR  = 3'd4,
    JAL = 3'd5
  } pcsrc_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } hz_state_t;

  // A branch or jump resolved in MEM redirects the front end.
  function automatic logic pc_taken(input logic [2:0] pcsrc, input logic zero);
    logic taken;
    taken = 1'b0;
    case (pcsrc)
      BEQ:         taken = zero;
      BNE:         taken = !zero;
      J, JR, JAL:  taken = 1'b1;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: per-register enables/flushes, PC redirect, sticky halt.
// Controls are combinational from FSM state and current inputs; counters update one cycle later.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       Rs_id,
  input  logic [4:0]       Rt_id,
  input  logic [4:0]       regOut_ex,
  input  logic             dREN_ex,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             atomic_mem,
  input  logic             halt_mem,
  input  logic             zero_mem,
  input  logic [2:0]       PCSrc_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             writeback_enable,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             writeback_flush,
  output logic             redirect,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic load_use;
  logic taken;

  // An SC is already a data write, so atomic_mem adds nothing to the wait condition.
  logic unused_atomic;
  assign unused_atomic = atomic_mem;

  assign mem_wait = (dREN_mem | dWEN_mem) & !dhit;
  assign load_use = dREN_ex && (regOut_ex != 5'd0) &&
                    ((regOut_ex == Rs_id) || (regOut_ex == Rt_id));
  assign taken    = pc_taken(PCSrc_mem, zero_mem);

  always_comb begin
    pc_en            = 1'b1;
    ifid_en          = 1'b1;
    idex_en          = 1'b1;
    exmem_en         = 1'b1;
    writeback_enable = 1'b1;
    ifid_flush       = 1'b0;
    idex_flush       = 1'b0;
    exmem_flush      = 1'b0;
    writeback_flush  = 1'b0;
    redirect         = 1'b0;
    state_d          = RUN;

    if (state_q == HALTED) begin
      pc_en            = 1'b0;
      ifid_en          = 1'b0;
      idex_en          = 1'b0;
      exmem_en         = 1'b0;
      writeback_enable = 1'b0;
      state_d          = HALTED;
    end else if ((state_q == MEMWAIT) && !dhit) begin
      // The outstanding access holds the whole pipe even if MEM controls change meanwhile.
      pc_en            = 1'b0;
      ifid_en          = 1'b0;
      idex_en          = 1'b0;
      exmem_en         = 1'b0;
      writeback_enable = 1'b0;
      writeback_flush  = 1'b1;
      state_d          = MEMWAIT;
    end else if (halt_mem) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = HALTED;
    end else if (mem_wait) begin
      pc_en            = 1'b0;
      ifid_en          = 1'b0;
      idex_en          = 1'b0;
      exmem_en         = 1'b0;
      writeback_enable = 1'b0;
      writeback_flush  = 1'b1;
      state_d          = MEMWAIT;
    end else if (taken) begin
      redirect    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (state_q != HALTED) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halt      = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expected controls and counts.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit;
  logic [4:0]  Rs_id, Rt_id, regOut_ex;
  logic        dREN_ex, dREN_mem, dWEN_mem, atomic_mem, halt_mem, zero_mem;
  logic [2:0]  PCSrc_mem;
  logic        pc_en, ifid_en, idex_en, exmem_en, writeback_enable;
  logic        ifid_flush, idex_flush, exmem_flush, writeback_flush;
  logic        redirect, halt;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .Rs_id(Rs_id), .Rt_id(Rt_id), .regOut_ex(regOut_ex), .dREN_ex(dREN_ex),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .atomic_mem(atomic_mem),
    .halt_mem(halt_mem), .zero_mem(zero_mem), .PCSrc_mem(PCSrc_mem),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .writeback_enable(writeback_enable), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .writeback_flush(writeback_flush), .redirect(redirect), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1;
    Rs_id = 5'd0; Rt_id = 5'd0; regOut_ex = 5'd0;
    dREN_ex = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0; atomic_mem = 1'b0;
    halt_mem = 1'b0; zero_mem = 1'b0; PCSrc_mem = 3'd0;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    chk("rst_halt", 32'(halt), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    chk("rst_pc_en", 32'(pc_en), 1);
    tick();
    nRST = 1'b1;

    // Load from r0 never creates a hazard.
    dREN_ex = 1'b1; regOut_ex = 5'd0; Rs_id = 5'd0; #1;
    chk("r0_pc_en", 32'(pc_en), 1);
    chk("r0_ifid_en", 32'(ifid_en), 1);
    chk("r0_idex_flush", 32'(idex_flush), 0);
    tick(); idle();

    // Load-use on Rs: stall 1
    dREN_ex = 1'b1; regOut_ex = 5'd5; Rs_id = 5'd5; #1;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_ifid_en", 32'(ifid_en), 0);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    chk("lu_exmem_en", 32'(exmem_en), 1);
    chk("lu_wb_en", 32'(writeback_enable), 1);
    tick(); idle(); #1;
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_after_pc_en", 32'(pc_en), 1);

    // Load-use on Rt: stall 2
    dREN_ex = 1'b1; regOut_ex = 5'd7; Rt_id = 5'd7; Rs_id = 5'd3; #1;
    chk("lu_rt_pc_en", 32'(pc_en), 0);
    tick(); idle();

    // BNE taken with concurrent load-use: flush 1, stall stays 2
    PCSrc_mem = 3'd2; zero_mem = 1'b0;
    dREN_ex = 1'b1; regOut_ex = 5'd5; Rs_id = 5'd5; #1;
    chk("bne_redirect", 32'(redirect), 1);
    chk("bne_ifid_flush", 32'(ifid_flush), 1);
    chk("bne_idex_flush", 32'(idex_flush), 1);
    chk("bne_exmem_flush", 32'(exmem_flush), 1);
    chk("bne_pc_en", 32'(pc_en), 1);
    chk("bne_wb_en", 32'(writeback_enable), 1);
    tick(); idle(); #1;
    chk("bne_flush_cnt", 32'(flush_cnt), 1);
    chk("bne_stall_cnt", 32'(stall_cnt), 2);

    // BEQ with zero=0 is not taken
    PCSrc_mem = 3'd1; zero_mem = 1'b0; #1;
    chk("beq_nt_redirect", 32'(redirect), 0);
    chk("beq_nt_exmem_flush", 32'(exmem_flush), 0);
    tick(); idle();

    // JAL always taken: flush 2
    PCSrc_mem = 3'd5; #1;
    chk("jal_redirect", 32'(redirect), 1);
    tick(); idle(); #1;
    chk("jal_flush_cnt", 32'(flush_cnt), 2);

    // Fetch miss: stall 3
    ihit = 1'b0; #1;
    chk("imiss_pc_en", 32'(pc_en), 0);
    chk("imiss_ifid_flush", 32'(ifid_flush), 1);
    chk("imiss_idex_en", 32'(idex_en), 1);
    chk("imiss_wb_en", 32'(writeback_enable), 1);
    tick(); idle();

    // Data miss for 3 cycles; third cycle drops dREN_mem to prove the wait is held in state.
    dREN_mem = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dREN_mem = 1'b0;
      #1;
      chk($sformatf("dmiss%0d_pc_en", i), 32'(pc_en), 0);
      chk($sformatf("dmiss%0d_exmem_en", i), 32'(exmem_en), 0);
      chk($sformatf("dmiss%0d_wb_en", i), 32'(writeback_enable), 0);
      chk($sformatf("dmiss%0d_wb_flush", i), 32'(writeback_flush), 1);
      tick();
    end
    dREN_mem = 1'b1; dhit = 1'b1; #1;
    chk("dhit_pc_en", 32'(pc_en), 1);
    chk("dhit_wb_flush", 32'(writeback_flush), 0);
    chk("dhit_wb_en", 32'(writeback_enable), 1);
    tick(); idle(); #1;
    chk("dmiss_stall_cnt", 32'(stall_cnt), 6);
    chk("dmiss_back_to_run", 32'(writeback_flush), 0);

    // Halt: the halt_mem cycle counts as a stall (7), HALTED cycles do not.
    halt_mem = 1'b1; #1;
    chk("hmem_pc_en", 32'(pc_en), 0);
    chk("hmem_exmem_flush", 32'(exmem_flush), 1);
    chk("hmem_wb_en", 32'(writeback_enable), 1);
    chk("hmem_halt", 32'(halt), 0);
    tick(); halt_mem = 1'b0; #1;
    chk("halted_halt", 32'(halt), 1);
    chk("halted_pc_en", 32'(pc_en), 0);
    chk("halted_wb_en", 32'(writeback_enable), 0);
    chk("halted_exmem_flush", 32'(exmem_flush), 0);
    for (int i = 0; i < 4; i++) begin
      ihit = i[0];
      tick();
      chk($sformatf("halted_stay%0d", i), 32'(halt), 1);
    end
    chk("halted_stall_cnt", 32'(stall_cnt), 7);
    idle();
    nRST = 1'b0; #1;
    chk("halt_rst_halt", 32'(halt), 0);
    chk("halt_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("halt_rst_flush_cnt", 32'(flush_cnt), 0);
    tick(); nRST = 1'b1;

    // Reset while in MEMWAIT drops the pending wait.
    dREN_mem = 1'b1; dhit = 1'b0;
    tick();
    dREN_mem = 1'b0; #1;
    chk("mw_held_wb_flush", 32'(writeback_flush), 1);
    nRST = 1'b0; #1;
    chk("mw_rst_wb_flush", 32'(writeback_flush), 0);
    tick(); nRST = 1'b1; #1;
    chk("mw_rst_pc_en", 32'(pc_en), 1);
    tick(); idle(); #1;
    chk("mw_rst_stall_cnt", 32'(stall_cnt), 0);

    // Saturation of the stall counter.
    ihit = 1'b0;
    repeat (65534) tick();
    chk("sat_pre_stall_cnt", 32'(stall_cnt), 32'h0000_FFFE);
    repeat (7) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat_flush_cnt", 32'(flush_cnt), 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating performance counters.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 ihit, dhit  in  1 each  instruction-fetch and data-memory completion strobes.
REQ-005 Rs_id, Rt_id  in  5 each  source registers of the instruction in ID.
REQ-006 regOut_ex  in  5  destination register in EX; dREN_ex  in  1  EX instruction is a load.
REQ-007 dREN_mem, dWEN_mem, atomic_mem, halt_mem, zero_mem  in  1 each  MEM-stage controls; PCSrc_mem  in  3  MEM-stage PC select.
REQ-008 pc_en, ifid_en, idex_en, exmem_en, writeback_enable  out  1 each  per-register load enables.
REQ-009 ifid_flush, idex_flush, exmem_flush, writeback_flush  out  1 each  per-register bubble inserts; flush overrides enable.
REQ-010 redirect  out  1  the PC loads the MEM-stage target, not PC+4.
REQ-011 halt  out  1  sticky halt indication.
REQ-012 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-013 FSM states: RUN, MEMWAIT, HALTED; outputs are combinational from the state and the current inputs.
REQ-014 Priority in RUN, highest first: halt_mem, memory wait, branch/jump taken, load-use, fetch miss, normal.
REQ-015 Memory wait = (dREN_mem|dWEN_mem) & !dhit, including atomic_mem SC; all enables 0; writeback_flush=1; next state MEMWAIT.
REQ-016 In MEMWAIT the memory-wait outputs persist until dhit=1; in that cycle the RUN rules apply with memory wait false; next state RUN.
REQ-017 Taken = (PCSrc_mem==BEQ & zero_mem) | (PCSrc_mem==BNE & !zero_mem) | PCSrc_mem in {J, JR, JAL}.
REQ-018 On taken: redirect=1, pc_en=1, ifid/idex/exmem flush=1, writeback_enable=1; this takes priority over load-use and fetch miss in the same cycle.
REQ-019 Load-use = dREN_ex & regOut_ex!=0 & (regOut_ex==Rs_id | regOut_ex==Rt_id): pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, writeback_enable=1, for exactly 1 cycle.
REQ-020 Fetch miss = !ihit: pc_en=0, ifid_flush=1, downstream stages advance.
REQ-021 Normal: all enables 1, all flushes 0, redirect=0.
REQ-022 halt_mem in RUN: pc_en=0, ifid/idex/exmem flush=1, writeback_enable=1; next state HALTED.
REQ-023 HALTED: all enables and flushes 0, halt=1; the block stays in HALTED until reset.
REQ-024 stall_cnt increments in each cycle with pc_en=0 outside HALTED; flush_cnt increments in each cycle with redirect=1; both saturate at all-ones.

Reset
REQ-025 nRST low: state=RUN; stall_cnt=flush_cnt=0; halt=0.
REQ-026 Reset asserted in MEMWAIT or HALTED returns the block to RUN asynchronously; no pending stall is retained.

Structure
REQ-027 cpu_types_pkg holds the PCSrc encoding: PC4=0, BEQ=1, BNE=2, J=3, JR=4, JAL=5; it also holds the hazard FSM state typedef.
REQ-028 Single flat module with no sub-module; one always_ff block holds state and counters.

Verification
REQ-029 dREN_ex=1, regOut_ex=5, Rs_id=5, ihit=dhit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-030 dREN_ex=1, regOut_ex=0, Rs_id=0 -> no stall; all enables 1.
REQ-031 PCSrc_mem=BNE, zero_mem=0, with a concurrent load-use -> redirect=1, three flushes, no stall; flush_cnt=1.
REQ-032 dREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> enables 0 and writeback_flush=1 for 3 cycles, RUN on the 4th; stall_cnt=3.
REQ-033 halt_mem=1 -> in the next cycle halt=1 and all enables 0; the block remains in HALTED despite ihit toggling; nRST low clears halt.
REQ-034 Force stall for 2^CNT_W+5 cycles -> stall_cnt holds at all-ones.
